// File: rtl/image_stream_tx.sv
// image_stream_tx: holds one RGB frame written by a host and streams it,
// one byte per clock in raster order, into the blur engine after a
// one-cycle start strobe, then waits for the engine's done level.
module image_stream_tx #(
  parameter int WIDTH  = 20,
  parameter int HEIGHT = 12,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              send,
  input  logic              blur_done,
  output logic              start,
  output logic [7:0]        pix_out,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        frames_sent
);

  localparam int N      = WIDTH * HEIGHT * 3;
  localparam int MEM_AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [ADDR_W:0] N_IDX = (ADDR_W + 1)'(N);

  typedef enum logic [1:0] {IDLE, START, STREAM, WAIT_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic              start_q, start_d;
  logic [7:0]        pix_q, pix_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic [7:0]        cnt_q, cnt_d;

  logic [7:0]        mem_q [N];
  logic [MEM_AW-1:0] rd_addr;
  logic [MEM_AW-1:0] wr_mem_addr;
  logic              wr_ok;

  // Host writes land only while idle and inside the frame.
  assign wr_ok       = wr_en && (state_q == IDLE) && ({1'b0, wr_addr} < N_IDX);
  assign wr_mem_addr = wr_addr[MEM_AW-1:0];
  // idx is 0 in START, so one read port serves both START and STREAM.
  assign rd_addr     = idx_q[MEM_AW-1:0];

  // Frame buffer: synchronous write, contents survive reset.
  // NOTE: no reset on the array -- a reset would turn the RAM into flops and
  // the host reloads the frame anyway.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_mem_addr] <= wr_data;
  end

  // State and registered-output storage.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      start_q      <= 1'b0;
      pix_q        <= 8'd0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      cnt_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      start_q      <= start_d;
      pix_q        <= pix_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (send) state_d = START;
      START:     state_d = STREAM;
      STREAM:    if (idx_q == N_IDX) state_d = WAIT_DONE;
      WAIT_DONE: if (blur_done) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and the byte index.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    start_d      = 1'b0;
    pix_d        = 8'd0;
    frame_done_d = 1'b0;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (send) begin
          start_d = 1'b1;
          idx_d   = '0;
        end
      end
      START: begin
        pix_d = mem_q[rd_addr];
        idx_d = (ADDR_W + 1)'(1);
      end
      STREAM: begin
        if (idx_q < N_IDX) begin
          pix_d = mem_q[rd_addr];
          idx_d = idx_q + (ADDR_W + 1)'(1);
        end
      end
      WAIT_DONE: begin
        if (blur_done) begin
          frame_done_d = 1'b1;
          cnt_d        = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign start       = start_q;
  assign pix_out     = pix_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frames_sent = cnt_q;

endmodule

// File: tb/tb_image_stream_tx.sv
// Testbench for image_stream_tx: random frames scored against a byte-array
// model; a monitor pops expected bytes/counts whenever start, the stream or
// frame_done appear. Geometry is reduced so 256 frames stay short.
module tb_image_stream_tx;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int AW = 7;
  localparam int N  = W * H * 3;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          send;
  logic          blur_done;
  logic          start;
  logic [7:0]    pix_out;
  logic          busy;
  logic          frame_done;
  logic [7:0]    frames_sent;

  image_stream_tx #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .send(send), .blur_done(blur_done), .start(start),
    .pix_out(pix_out), .busy(busy), .frame_done(frame_done),
    .frames_sent(frames_sent)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         vectors    = 0;
  int         miscompares = 0;
  logic [7:0] ref_mem [N];
  logic [7:0] byte_q [$];
  logic [7:0] fd_q [$];
  logic [7:0] exp_frames;
  bit         model_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares everything the DUT presents, at the falling edge.
  initial begin : monitor
    int   mon_rem;
    logic prev_start;
    mon_rem    = 0;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_rem    = 0;
        prev_start = 1'b0;
      end else begin
        if (mon_rem > 0) begin
          check("busy_streaming", busy, 1);
          if (byte_q.size() == 0) check("byte_queue_empty", 1, 0);
          else check("pix_out", pix_out, byte_q.pop_front());
          mon_rem--;
        end else begin
          check("pix_idle", pix_out, 0);
        end
        if (start) begin
          check("start_width", prev_start, 0);
          check("start_expected", byte_q.size(), N);
          mon_rem = N;
        end
        prev_start = start;
        if (frame_done) begin
          if (fd_q.size() == 0) check("frame_done_unexpected", 1, 0);
          else check("frames_sent", frames_sent, fd_q.pop_front());
          check("busy_at_done", busy, 0);
        end
      end
    end
  end

  // Host write; the model mirrors what the buffer should accept.
  task automatic write_byte(input int addr, input logic [7:0] data);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = data;
    if (!model_busy && addr < N) ref_mem[addr] = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // One full frame: expected bytes and count are queued at send time.
  task automatic run_frame(input bit pre_done, input int extra, input bit intrude,
                           input bit wr0, input logic [7:0] wr0_data);
    int cnt;
    int lat_exp;
    if (wr0) begin
      ref_mem[0] = wr0_data;
      wr_en   = 1'b1;
      wr_addr = '0;
      wr_data = wr0_data;
    end
    for (int i = 0; i < N; i++) byte_q.push_back(ref_mem[i]);
    exp_frames = exp_frames + 8'd1;
    fd_q.push_back(exp_frames);
    blur_done = pre_done;
    send      = 1'b1;
    @(posedge clk); #1;
    send       = 1'b0;
    wr_en      = 1'b0;
    model_busy = 1'b1;
    cnt        = 1;
    while (!frame_done && cnt < 4 * N) begin
      send  = 1'b0;
      wr_en = 1'b0;
      if (intrude && cnt == 20) begin
        send    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = AW'(5);
        wr_data = 8'hFF;
      end
      if (!pre_done && cnt >= N + 2 + extra) blur_done = 1'b1;
      @(posedge clk); #1;
      cnt++;
    end
    send    = 1'b0;
    wr_en   = 1'b0;
    lat_exp = pre_done ? N + 3 : N + 3 + extra;
    check("frame_done_latency", cnt, lat_exp);
    check("busy_after_done", busy, 0);
    blur_done  = 1'b0;
    model_busy = 1'b0;
    @(posedge clk); #1;
    check("frame_done_width", frame_done, 0);
  endtask

  initial begin : stimulus
    reset      = 1'b1;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = 8'd0;
    send       = 1'b0;
    blur_done  = 1'b0;
    model_busy = 1'b0;
    exp_frames = 8'd0;
    #2;
    check("rst_start", start, 0);
    check("rst_pix", pix_out, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frames_sent", frames_sent, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Ramp pattern, then a uniform frame.
    for (int i = 0; i < N; i++) write_byte(i, 8'(i));
    run_frame(1'b0, 0, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < N; i++) write_byte(i, 8'h80);
    run_frame(1'b0, 2, 1'b0, 1'b0, 8'd0);

    // send and a write while streaming are both ignored.
    run_frame(1'b0, 1, 1'b1, 1'b0, 8'd0);
    run_frame(1'b0, 0, 1'b0, 1'b0, 8'd0);

    // Out-of-range writes, then a write to byte 0 in the send cycle.
    write_byte(N, 8'h11);
    write_byte((1 << AW) - 1, 8'h22);
    run_frame(1'b0, 0, 1'b0, 1'b0, 8'd0);
    run_frame(1'b0, 3, 1'b0, 1'b1, 8'h5A);

    // Reset in the middle of a frame.
    for (int k = 0; k < 4; k++) write_byte($urandom_range(0, N - 1), 8'($urandom));
    for (int i = 0; i < N; i++) byte_q.push_back(ref_mem[i]);
    exp_frames = exp_frames + 8'd1;
    fd_q.push_back(exp_frames);
    send = 1'b1;
    @(posedge clk); #1;
    send = 1'b0;
    repeat (51) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("midrst_start", start, 0);
    check("midrst_pix", pix_out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_frame_done", frame_done, 0);
    check("midrst_frames_sent", frames_sent, 0);
    byte_q.delete();
    fd_q.delete();
    exp_frames = 8'd0;
    @(posedge clk); #1;
    reset = 1'b0;
    run_frame(1'b0, 0, 1'b0, 1'b0, 8'd0);

    // Done already high on entry, then enough frames to wrap the counter.
    run_frame(1'b1, 0, 1'b0, 1'b0, 8'd0);
    for (int f = 0; f < 254; f++) begin
      int nw;
      nw = $urandom_range(0, 2);
      for (int k = 0; k < nw; k++) write_byte($urandom_range(0, (1 << AW) - 1), 8'($urandom));
      run_frame($urandom_range(0, 7) == 0, $urandom_range(0, 3), 1'b0, 1'b0, 8'd0);
    end
    check("frames_sent_final", frames_sent, exp_frames);
    check("frames_sent_wrapped", frames_sent, 0);
    check("leftover_bytes", byte_q.size(), 0);
    check("leftover_frames", fd_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/image_stream_tx.md
# image_stream_tx

Transmit-side feeder for the blur engine's pixel input. It holds one RGB frame in an internal byte buffer that a host fills through a simple write port. On command it issues the one-cycle `start` strobe and streams the frame one byte per clock in raster order (R, G, B per pixel), then waits for the engine's `done` level. It sits between the host/testbench memory loader and `image_in`/`start`/`done` of the blur engine.

## Interface
- `WIDTH`, default 20: pixels per row.
- `HEIGHT`, default 12: rows per frame.
- `ADDR_W`, default 10: byte address width; must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT*3.
- `clk` in 1: the single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `wr_en` in 1: host byte write strobe.
- `wr_addr` in ADDR_W: byte address, equal to (row*WIDTH+col)*3 + channel (0=R, 1=G, 2=B).
- `wr_data` in 8: byte to write.
- `send` in 1: request to stream the buffered frame.
- `blur_done` in 1: `done` level from the blur engine.
- `start` out 1: one-cycle start strobe to the blur engine.
- `pix_out` out 8: byte stream to the blur engine's `image_in`.
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: one-cycle pulse when the frame has been consumed.
- `frames_sent` out 8: count of completed frames; wraps 255→0.

## Operation
- N = WIDTH*HEIGHT*3 bytes; the byte index `idx` is ADDR_W+1 bits wide and counts 0..N.
- Buffer: N×8 array with a synchronous write. It is not cleared by reset.
- Writes:
  - Accepted only in IDLE with `wr_addr` < N.
  - Writes with `wr_addr` ≥ N are ignored.
  - Writes while `busy` are ignored; the buffer does not change.
- States: IDLE, START, STREAM, WAIT_DONE.
  - IDLE: when `send` is sampled high, set `start`←1, `idx`←0, go to START.
  - START: set `start`←0, `pix_out`←mem[0], `idx`←1, go to STREAM.
  - STREAM, `idx` < N: `pix_out`←mem[idx], `idx`←idx+1.
  - STREAM, `idx` == N: `pix_out`←0, go to WAIT_DONE.
  - WAIT_DONE: when `blur_done` is sampled high, `frame_done`←1 for one cycle, `frames_sent`←+1, go to IDLE.
- `send` is ignored outside IDLE; it is not queued.
- `blur_done` is a level signal. If it is already high on entry to WAIT_DONE, the exit happens on the first WAIT_DONE edge. The host must reset the engine between frames.
- `pix_out` is 0 whenever the block is not in START→STREAM delivery.

## Timing
- All outputs are registered.
- Reset values: `start`=0, `pix_out`=0, `busy`=0, `frame_done`=0, `frames_sent`=0, state=IDLE, `idx`=0.
- `send` sampled at edge E0 → `start` is high during cycle E0..E1.
- At E1 the engine sees `start`, and the block drives mem[0].
- The engine samples byte k at edge E(k+2); the last byte mem[N-1] is sampled at E(N+1).
- `busy` rises at E0 and falls at the edge `frame_done` is asserted.
- Minimum send-to-`frame_done` is N+3 edges.
- Reset mid-stream: all outputs go to their reset values immediately (asynchronously). `frames_sent` is cleared. A partial frame is abandoned and the engine must also be reset.
- `wr_en` and `send` in the same IDLE cycle: the write lands, but streaming reads mem[0] at E1. A write to address 0 on the same edge is therefore visible in the stream.

## Test plan
- **Write/readback:** fill the buffer with byte i = i[7:0] for i=0..719, pulse `send`.
  - `start` is high for exactly 1 cycle.
  - `pix_out` = 0x00, 0x01, …, 0xCF (i=719→0xCF) on consecutive cycles starting 1 cycle after `start`.
  - Then `pix_out`=0.
- **End-to-end with the blur engine:** uniform frame, every byte 0x80, engine reset beforehand.
  - The engine's output bytes all equal 0x80.
  - `frame_done` pulses once; `frames_sent`=1.
- **Busy protection:**
  - Issue `send` and a write of 0xFF to address 5 while in STREAM.
  - No restart occurs; byte 5 is unchanged on the next frame.
- **Out-of-range write:** writing `wr_addr`=720 leaves all 720 bytes unchanged.
- **Reset mid-stream:** assert `reset` at byte 300.
  - `start`/`pix_out`/`busy`/`frames_sent` are 0 in the same cycle.
  - The next `send` streams from byte 0.
- **Pre-asserted done and counter wrap:**
  - With `blur_done` held at 1, `frame_done` occurs at send+N+3 edges.
  - Repeating 256 frames returns `frames_sent` to 0.
